// File: rtl/stream_rr_arb.sv
// N-input round-robin stream arbiter with a registered single-entry output stage.
// Each forwarded item is tagged with the index of the input that supplied it.
module stream_rr_arb #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clk_en,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   i_ready,
  input  logic [N*W-1:0] i,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [W-1:0]   o,
  output logic [IW-1:0]  o_id
);

  logic           o_valid_q, o_valid_d;
  logic [W-1:0]   o_q, o_d;
  logic [IW-1:0]  o_id_q, o_id_d;
  logic [IW-1:0]  ptr_q, ptr_d;

  logic [W-1:0]   item [N];
  logic [IW-1:0]  gnt;
  logic [31:0]    idx;
  logic           found;
  logic           any;
  logic           load;

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign item[k] = i[k*W +: W];
  end

  assign any = |i_valid;
  // Gating with rst_n keeps i_ready low for the whole reset window.
  assign load = clk_en && rst_n && (!o_valid_q || o_ready);

  // Scan from ptr upward with a wrap at N-1, not at 2^IW-1.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = {{(32 - IW){1'b0}}, ptr_q} + off;
      if (idx >= N) idx = idx - N;
      if (!found && i_valid[idx[IW-1:0]]) begin
        found = 1'b1;
        gnt   = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    i_ready = '0;
    if (load && any) i_ready[gnt] = 1'b1;
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_d       = o_q;
    o_id_d    = o_id_q;
    ptr_d     = ptr_q;
    if (load && any) begin
      o_valid_d = 1'b1;
      o_d       = item[gnt];
      o_id_d    = gnt;
      ptr_d     = (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;
    end else if (clk_en && o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      o_q       <= '0;
      o_id_q    <= '0;
      ptr_q     <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_q       <= o_d;
      o_id_q    <= o_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o       = o_q;
  assign o_id    = o_id_q;

endmodule
